// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard sequencer.
package pipe_pkg;
  localparam int          REG_W = 5;
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef enum logic {RUN, REDIRECT} state_e;

  typedef struct packed {
    logic pc_en;
    logic ifid_stall;
    logic ifid_flush;
    logic idex_stall;
    logic idex_flush;
    logic exmem_stall;
  } ctl_t;

  function automatic logic load_use(
    input logic             ex_valid,
    input logic             ex_mem_read,
    input logic [REG_W-1:0] ex_rd,
    input logic             id_valid,
    input logic             use_rs1,
    input logic             use_rs2,
    input logic [REG_W-1:0] rs1,
    input logic [REG_W-1:0] rs2
  );
    return ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
           ((use_rs1 & (rs1 == ex_rd)) | (use_rs2 & (rs2 == ex_rd)));
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             en_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (en_i && cnt_q != '1)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze, redirect flush,
// load-use interlock, plus perf counters and a sticky memory-timeout flag.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [3:0]  RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TMO    = 16'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        tmo_q, tmo_d;
  ctl_t        ctl, ctl_g;
  logic        mem_wait, hazard, redir_evt;

  assign mem_wait = mem_req & ~mem_ready;
  assign hazard   = load_use(ex_valid, ex_mem_read, ex_rd, id_valid,
                             id_use_rs1, id_use_rs2, id_rs1, id_rs2);

  always_comb begin
    ctl       = '{pc_en: 1'b1, default: 1'b0};
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    redir_evt = 1'b0;
    if (mem_wait) begin
      // Whole pipe frozen; a pending redirect re-presents once EX moves again.
      ctl = '{pc_en: 1'b0, ifid_stall: 1'b1, idex_stall: 1'b1, exmem_stall: 1'b1, default: 1'b0};
    end else if (ex_redirect) begin
      ctl.ifid_flush = 1'b1;
      ctl.idex_flush = 1'b1;
      redir_evt      = 1'b1;
      rcnt_d         = RELOAD;
      state_d        = (RELOAD != '0) ? REDIRECT : RUN;
    end else if (state_q == REDIRECT) begin
      ctl.ifid_flush = 1'b1;
      rcnt_d         = rcnt_q - 1'b1;
      if (rcnt_q == 4'd1) state_d = RUN;
    end else if (hazard) begin
      ctl.pc_en      = 1'b0;
      ctl.ifid_stall = 1'b1;
      ctl.idex_flush = 1'b1;
    end
  end

  always_comb begin
    wcnt_d = '0;
    tmo_d  = tmo_q;
    if (mem_wait) begin
      wcnt_d = (wcnt_q != TMO) ? wcnt_q + 1'b1 : wcnt_q;
      if (wcnt_q >= TMO - 1'b1) tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= RUN;
      rcnt_q  <= '0;
      wcnt_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      wcnt_q  <= wcnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Everything, pc_en included, is held low while reset is asserted.
  assign ctl_g       = rst_ ? ctl : '0;
  assign pc_en       = ctl_g.pc_en;
  assign ifid_stall  = ctl_g.ifid_stall;
  assign ifid_flush  = ctl_g.ifid_flush;
  assign idex_stall  = ctl_g.idex_stall;
  assign idex_flush  = ctl_g.idex_flush;
  assign exmem_stall = ctl_g.exmem_stall;
  assign mem_timeout = tmo_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_(rst_), .en_i(~ctl_g.pc_en), .clr_i(1'b0), .cnt_o(stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst_(rst_), .en_i(redir_evt), .clr_i(1'b0), .cnt_o(flush_cnt)
  );
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Drives the IF_ID, ID_EX and EX_MEM pipeline registers and the PC enable.
- Resolves three events:
  - load-use hazards (one-bubble interlock);
  - taken branches/jumps resolved in EX (redirect flush, optionally multi-cycle for fetch latency);
  - data-memory wait (full freeze).
- Also keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
- FLUSH_CYCLES, 1, total cycles ifid_flush is held after a taken branch (1..15).
- MEM_TIMEOUT, 255, consecutive wait cycles after which mem_timeout sets (1..65535).
- CNT_W, 32, width of the saturating perf counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  5  ID source register 1.
- id_rs2  in  5  ID source register 2.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_valid  in  1  EX holds a real instruction.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC may update.
- ifid_stall  out  1  hold IF_ID.
- ifid_flush  out  1  squash IF_ID to a NOP.
- idex_stall  out  1  hold ID_EX.
- idex_flush  out  1  insert a bubble into ID_EX.
- exmem_stall  out  1  hold EX_MEM.
- mem_timeout  out  1  sticky error flag.
- stall_cnt  out  CNT_W  cycles with pc_en=0.
- flush_cnt  out  CNT_W  taken-redirect events.

Behaviour:
- Reset:
  - Decided: one clock; reset is asynchronous and active-low (ports clk, rst_).
  - While rst_=0: state=RUN, redirect counter=0, wait counter=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
  - While rst_=0, all stall/flush outputs=0 and pc_en=0.
  - Reset mid-redirect or mid-wait abandons the sequence.
- Stall/flush outputs are combinational from inputs and state; they act at the same clock edge (zero latency). Counters and state are registered.
- Priority, highest first: MEM_WAIT freeze > redirect > redirect tail > load-use > run.
- mem_wait = mem_req & ~mem_ready:
  - pc_en=0, ifid_stall=1, idex_stall=1, exmem_stall=1, no flushes.
  - ex_redirect is ignored this cycle; EX is frozen, so the redirect re-presents after the wait.
- Redirect (ex_redirect=1, no mem_wait):
  - pc_en=1, ifid_flush=1, idex_flush=1, flush_cnt+=1.
  - Redirect counter loads FLUSH_CYCLES-1. If nonzero, next state=REDIRECT, else RUN.
- REDIRECT state:
  - ifid_flush=1 and pc_en=1 for each remaining count; counter decrements.
  - Exits to RUN when the counter reaches 1→0.
  - During mem_wait the counter freezes.
  - A new ex_redirect reloads the counter.
- Load-use hazard = ex_valid & ex_mem_read & (ex_rd≠0) & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Response: pc_en=0, ifid_stall=1, idex_flush=1 for exactly one cycle; the load then advances, clearing the hazard.
  - Suppressed by redirect, since the ID instruction is being squashed.
- RUN, no event: pc_en=1, all stall/flush outputs=0.
- Wait counter:
  - Increments on each mem_wait cycle; clears on any cycle without mem_wait.
  - Reaching MEM_TIMEOUT sets mem_timeout, which stays set until rst_.
  - The counter saturates at MEM_TIMEOUT.
- stall_cnt: increments on every cycle with pc_en=0 after reset.
- Both perf counters saturate at all-ones; no wrap.
- ifid_stall and ifid_flush are never asserted in the same cycle.

Decomposition:
- Shared package pipe_pkg holds:
  - state enum RUN/REDIRECT;
  - NOP encoding 32'h00000013;
  - register-index width 5;
  - a function for the load-use compare.
- One natural sub-module: sat_counter (CNT_W, enable, clear), instantiated twice.

Test Plan:
- Load-use: `lw x5` in EX, `add x6,x5,x1` in ID → exactly one cycle of pc_en=0, ifid_stall=1, idex_flush=1; stall_cnt=1.
- ex_rd=0 with a matching rs1=0 → no stall.
- Redirect with FLUSH_CYCLES=3: ex_redirect pulse → ifid_flush high 3 consecutive cycles, idex_flush only in the first, flush_cnt=1.
- Memory wait: mem_req=1, mem_ready=0 for 4 cycles with ex_redirect=1 → full freeze 4 cycles with no flush; on mem_ready the redirect flush occurs the following cycle.
- Simultaneous load-use and ex_redirect → redirect response only; stall_cnt unchanged.
- MEM_TIMEOUT=8, mem_ready held low 10 cycles → mem_timeout rises after the 8th wait cycle and stays set after mem_ready=1.
- rst_ asserted asynchronously mid-REDIRECT (count 2) → all outputs and counters 0 immediately; after release, state is RUN with pc_en=1.
